ncl_word_capture: RTL and testbench
===================================

// Module: ncl_word_capture
// PURPOSE
//  Clocked consumer at the output of the full-word NCL counter ring.
//  - Samples WIDTH dual-rail sum bits (one per ring slice) and converts each complete DATA wavefront to a binary word.
//  - Returns the four-phase completion (sumcomp) that sequences the rings, so it is the only clocked stage at the ring boundary.
//  - Checks that consecutive words increment by one.
// PARAMETERS
//  WIDTH        32  number of counter bits / dual-rail pairs
//  SYNC_STAGES  2   flop stages on every rail before completion detection (>=2)
//  CHECK_INC    1   1 = enable the sequence (+1) check; 0 = seq_err tied 0
// PORTS
//  clk          in   1      sampling clock
//  init_n       in   1      asynchronous, active-low reset
//  sum_r0       in   WIDTH  rail0 (logic 0) of each sum bit; async, from ring
//  sum_r1       in   WIDTH  rail1 (logic 1) of each sum bit; async, from ring
//  sumcomp      out  1      completion to rings: 1 = DATA taken, send NULL; 0 = send DATA
//  out_data     out  WIDTH  captured binary word
//  out_valid    out  1      out_data holds an unconsumed word
//  out_ready    in   1      downstream accepts out_data when out_valid & out_ready
//  word_cnt     out  16     words captured since reset, wraps at 2^16
//  illegal_err  out  1      sticky: some bit had both rails high
//  seq_err      out  1      sticky: captured word != previous word + 1
// BEHAVIOUR
//  Reset (init_n=0, async):
//  - sumcomp=0, out_valid=0, out_data=0, word_cnt=0, both errors 0, state=WAIT_DATA.
//  - Reset mid-operation drops sumcomp immediately; the rings are re-initialised by their own init.
//  Synchronisation:
//  - Every rail passes through SYNC_STAGES flops; detection uses only synchronised copies (s_r0/s_r1).
//  - NCL wavefronts are monotonic, so a completion, once seen, is stable until sumcomp changes.
//  - all_data = AND over i of (s_r0[i]^s_r1[i]).
//  - all_null = NOR over all s_r0|s_r1.
//  - illegal  = OR over i of (s_r0[i]&s_r1[i]).
//  FSM (2 states, registered sumcomp):
//  - WAIT_DATA, sumcomp=0:
//    - if all_data & !illegal & (!out_valid | out_ready): load out_data=s_r1, out_valid=1, word_cnt+=1, sumcomp<=1, go to WAIT_NULL.
//    - else stay. A full hold register with out_ready=0 back-pressures and stalls the ring.
//  - WAIT_NULL, sumcomp=1:
//    - if all_null: sumcomp<=0, go to WAIT_DATA.
//    - partial NULL: stay.
//  Handshake:
//  - out_valid clears on out_valid&out_ready unless a new word loads in the same cycle.
//  - Load wins: out_valid stays 1 and out_data takes the new word.
//  Latency:
//  - Last rail rising -> sumcomp/out_valid high = SYNC_STAGES+1 clk (hold register free).
//  - Last rail falling -> sumcomp low = SYNC_STAGES+1 clk.
//  Errors:
//  - illegal_err sets whenever illegal=1 (any state). Such a word is never captured; the FSM waits.
//  - seq_err sets on load when CHECK_INC=1, word_cnt!=0 and s_r1 != prev+1 mod 2^WIDTH.
//  - prev = last loaded word. Wrap {WIDTH{1}} -> 0 is legal. The first word after reset is never checked.
//  - Errors clear only on reset.
// STRUCTURE
//  - Package ncl_pkg:
//    - typedef dual_rail_t {r1,r0}
//    - enum cap_state_e {WAIT_DATA, WAIT_NULL}
//    - localparams ACK_DATA=1'b1, ACK_NULL=1'b0
//  - Sub-module ncl_sync_vec #(W, STAGES): async-reset flop chain per bit, reset value 0 (=NULL).
//    - Instantiated once for rail0 and once for rail1.
//  - Completion trees, FSM, hold register, counter and checks live in ncl_word_capture.
// TESTING
//  1. Reset, then drive word 0x00000005 as DATA -> sumcomp=1 and out_valid=1 at cycle SYNC_STAGES+1; out_data=5, word_cnt=1.
//  2. Skewed rails: bits arrive one per cycle over 32 cycles -> no capture until the last bit; captured word is exact.
//  3. Words 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 with NULL between -> seq_err stays 0. Then 0x00000005 -> seq_err=1.
//  4. out_ready=0 with out_valid=1, second DATA applied -> sumcomp stays 0 and out_data unchanged.
//     Raise out_ready -> new word loads the same cycle, out_valid stays 1.
//  5. Bit 7 with both rails high -> illegal_err=1, no load, sumcomp stays 0.
//  6. init_n low while in WAIT_NULL -> sumcomp, out_valid, counters and errors are 0 asynchronously; FSM restarts in WAIT_DATA.

Source files
------------

// File: rtl/ncl_pkg.sv
// Shared types and constants for the NCL ring-boundary capture stage.
package ncl_pkg;

  typedef struct packed {
    logic r1;
    logic r0;
  } dual_rail_t;

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } cap_state_e;

  localparam logic ACK_DATA = 1'b1;
  localparam logic ACK_NULL = 1'b0;

  // A dual-rail bit carries DATA when exactly one rail is high.
  function automatic logic is_data(input dual_rail_t b);
    return b.r1 ^ b.r0;
  endfunction

  // Both rails high is never a legal NCL encoding.
  function automatic logic is_illegal(input dual_rail_t b);
    return b.r1 & b.r0;
  endfunction

endpackage

// File: rtl/ncl_sync_vec.sv
// Per-bit flop chain bringing asynchronous rails into the clk domain; resets to NULL (0).
module ncl_sync_vec #(
  parameter int unsigned W      = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ncl_word_capture.sv
// Clocked consumer at the NCL counter-ring output: captures DATA wavefronts as binary
// words, returns four-phase completion and checks the +1 sequence.
module ncl_word_capture
  import ncl_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CHECK_INC   = 1
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic [WIDTH-1:0] sum_r0,
  input  logic [WIDTH-1:0] sum_r1,
  output logic             sumcomp,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      word_cnt,
  output logic             illegal_err,
  output logic             seq_err
);

  logic [WIDTH-1:0] s_r0;
  logic [WIDTH-1:0] s_r1;

  ncl_sync_vec #(.W(WIDTH), .STAGES(SYNC_STAGES)) u_sync_r0 (
    .clk   (clk),
    .rst_n (init_n),
    .d     (sum_r0),
    .q     (s_r0)
  );

  ncl_sync_vec #(.W(WIDTH), .STAGES(SYNC_STAGES)) u_sync_r1 (
    .clk   (clk),
    .rst_n (init_n),
    .d     (sum_r1),
    .q     (s_r1)
  );

  // Completion trees over the synchronised rails.
  logic       all_data_c;
  logic       all_null_c;
  logic       illegal_c;
  dual_rail_t bit_c;

  always_comb begin
    all_data_c = 1'b1;
    illegal_c  = 1'b0;
    bit_c      = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bit_c.r1   = s_r1[i];
      bit_c.r0   = s_r0[i];
      all_data_c = all_data_c & is_data(bit_c);
      illegal_c  = illegal_c | is_illegal(bit_c);
    end
    all_null_c = ~|(s_r0 | s_r1);
  end

  cap_state_e state;
  cap_state_e state_next;
  logic       sumcomp_next;
  logic       load_c;
  logic       seq_hit_c;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state   <= WAIT_DATA;
      sumcomp <= ACK_NULL;
    end else begin
      state   <= state_next;
      sumcomp <= sumcomp_next;
    end
  end

  always_comb begin
    state_next   = state;
    sumcomp_next = sumcomp;
    load_c       = 1'b0;
    case (state)
      WAIT_DATA: begin
        if (all_data_c && !illegal_c && (!out_valid || out_ready)) begin
          load_c       = 1'b1;
          sumcomp_next = ACK_DATA;
          state_next   = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if (all_null_c) begin
          sumcomp_next = ACK_NULL;
          state_next   = WAIT_DATA;
        end
      end
      default: begin
        sumcomp_next = ACK_NULL;
        state_next   = WAIT_DATA;
      end
    endcase
  end

  // out_data always holds the last loaded word, so it doubles as the sequence reference.
  assign seq_hit_c = (CHECK_INC != 0) && (word_cnt != 16'd0) &&
                     (s_r1 != out_data + WIDTH'(1));

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      word_cnt    <= '0;
      illegal_err <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      if (load_c) begin
        out_data  <= s_r1;
        out_valid <= 1'b1;
        word_cnt  <= word_cnt + 16'd1;
        if (seq_hit_c) seq_err <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (illegal_c) illegal_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ncl_word_capture.sv
// Self-checking bench for ncl_word_capture against a word-level reference model.
module tb_ncl_word_capture;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SYNC  = 2;

  logic             clk;
  logic             init_n;
  logic [WIDTH-1:0] sum_r0;
  logic [WIDTH-1:0] sum_r1;
  logic             sumcomp;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      word_cnt;
  logic             illegal_err;
  logic             seq_err;

  ncl_word_capture #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .CHECK_INC(1)) dut (
    .clk         (clk),
    .init_n      (init_n),
    .sum_r0      (sum_r0),
    .sum_r1      (sum_r1),
    .sumcomp     (sumcomp),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .word_cnt    (word_cnt),
    .illegal_err (illegal_err),
    .seq_err     (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Word-level reference model.
  logic [31:0] m_prev;
  logic [15:0] m_cnt;
  logic        m_seq;
  logic        m_ill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = '0;
    m_cnt  = '0;
    m_seq  = 1'b0;
    m_ill  = 1'b0;
  endtask

  task automatic model_capture(input logic [31:0] w);
    if (m_cnt != 16'd0 && w != m_prev + 32'd1) m_seq = 1'b1;
    m_prev = w;
    m_cnt  = m_cnt + 16'd1;
  endtask

  task automatic check_capture(input logic [31:0] w);
    check("valid", 32'(out_valid), 32'd1);
    check("data", out_data, w);
    check("cnt", 32'(word_cnt), 32'(m_cnt));
    check("seq_err", 32'(seq_err), 32'(m_seq));
    check("illegal_err", 32'(illegal_err), 32'(m_ill));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sumcomp(input logic val, input string tag);
    int n = 0;
    while (sumcomp !== val && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(sumcomp), 32'(val));
  endtask

  task automatic drive_data(input logic [31:0] w);
    sum_r1 = w;
    sum_r0 = ~w;
  endtask

  task automatic drive_null();
    sum_r1 = '0;
    sum_r0 = '0;
  endtask

  task automatic do_reset();
    init_n    = 1'b0;
    out_ready = 1'b1;
    drive_null();
    model_reset();
    tick();
    tick();
    init_n = 1'b1;
    tick();
  endtask

  // Sends one word with random per-bit skew, then returns the ring to NULL.
  task automatic send_word(input logic [31:0] w, input int skew);
    int d[32];
    for (int i = 0; i < 32; i++) d[i] = int'($urandom_range(skew, 0));
    for (int c = 0; c <= skew; c++) begin
      for (int i = 0; i < 32; i++)
        if (d[i] == c) begin
          sum_r1[i] = w[i];
          sum_r0[i] = ~w[i];
        end
      tick();
    end
    wait_sumcomp(1'b1, "ack_data");
    model_capture(w);
    check_capture(w);
    for (int c = 0; c <= skew; c++) begin
      for (int i = 0; i < 32; i++)
        if (d[i] == c) begin
          sum_r1[i] = 1'b0;
          sum_r0[i] = 1'b0;
        end
      tick();
    end
    wait_sumcomp(1'b0, "ack_null");
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] a;
    init_n    = 1'b0;
    out_ready = 1'b1;
    drive_null();
    model_reset();
    #2;
    check("rst_sumcomp", 32'(sumcomp), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_cnt", 32'(word_cnt), 32'd0);
    check("rst_errs", {30'd0, illegal_err, seq_err}, 32'd0);
    tick();
    init_n = 1'b1;
    tick();

    // Test 1: latency of first word.
    drive_data(32'h0000_0005);
    repeat (SYNC) tick();
    check("lat_early", 32'(sumcomp), 32'd0);
    tick();
    check("lat_sumcomp", 32'(sumcomp), 32'd1);
    model_capture(32'h0000_0005);
    check_capture(32'h0000_0005);
    drive_null();
    repeat (SYNC) tick();
    check("null_early", 32'(sumcomp), 32'd1);
    tick();
    check("null_lat", 32'(sumcomp), 32'd0);

    // Test 2: one bit per cycle.
    w = $urandom();
    for (int i = 0; i < 32; i++) begin
      sum_r1[i] = w[i];
      sum_r0[i] = ~w[i];
      tick();
      if (i % 8 == 7 && i != 31) check("skew_hold", 32'(sumcomp), 32'd0);
    end
    tick();
    check("skew_hold_last", 32'(sumcomp), 32'd0);
    wait_sumcomp(1'b1, "skew_ack");
    model_capture(w);
    check_capture(w);
    drive_null();
    wait_sumcomp(1'b0, "skew_null");

    // Test 3: wrap-around is a legal increment, a jump is not.
    do_reset();
    send_word(32'hFFFF_FFFE, 2);
    send_word(32'hFFFF_FFFF, 3);
    send_word(32'h0000_0000, 1);
    check("wrap_seq_clean", 32'(seq_err), 32'd0);
    send_word(32'h0000_0005, 2);
    check("jump_seq_err", 32'(seq_err), 32'd1);

    // Test 4: back-pressure stalls the ring; load wins over consume.
    do_reset();
    out_ready = 1'b0;
    a = $urandom();
    send_word(a, 2);
    drive_data(a + 32'd1);
    repeat (8) tick();
    check("bp_sumcomp", 32'(sumcomp), 32'd0);
    check("bp_data", out_data, a);
    check("bp_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_release", 32'(sumcomp), 32'd1);
    model_capture(a + 32'd1);
    check_capture(a + 32'd1);
    drive_null();
    wait_sumcomp(1'b0, "bp_null");

    // Randomized traffic: mostly +1, sometimes a jump.
    for (int k = 0; k < 20; k++) begin
      w = ($urandom_range(3, 0) == 0) ? $urandom() : m_prev + 32'd1;
      send_word(w, int'($urandom_range(4, 0)));
    end

    // Test 5: both rails high on bit 7 blocks capture.
    w = m_prev + 32'd1;
    sum_r1 = w | 32'h0000_0080;
    sum_r0 = ~w | 32'h0000_0080;
    repeat (6) tick();
    m_ill = 1'b1;
    check("ill_err", 32'(illegal_err), 32'd1);
    check("ill_sumcomp", 32'(sumcomp), 32'd0);
    check("ill_cnt", 32'(word_cnt), 32'(m_cnt));
    sum_r1[7] = w[7];
    sum_r0[7] = ~w[7];
    wait_sumcomp(1'b1, "ill_recover");
    model_capture(w);
    check_capture(w);

    // Test 6: asynchronous reset while in WAIT_NULL.
    #2;
    init_n = 1'b0;
    #1;
    check("arst_sumcomp", 32'(sumcomp), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_cnt", 32'(word_cnt), 32'd0);
    check("arst_errs", {30'd0, illegal_err, seq_err}, 32'd0);
    model_reset();
    drive_null();
    tick();
    init_n = 1'b1;
    tick();
    send_word(32'h0000_1234, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
